// File: rtl/affine_xform_if.sv
// Handshake bundle between the affine sequencer and the shared sequential multiplier.
//   master : sequencer side, drives mul_start/mul_a/mul_b, receives product, done and busy
//   slave  : multiplier side
interface affine_xform_if #(
  parameter int unsigned WIDTH = 16
);
  logic               mul_start;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0] mul_result;
  logic               mul_done;
  logic               mul_busy;

  modport master (
    output mul_start, mul_a, mul_b,
    input  mul_result, mul_done, mul_busy
  );

  modport slave (
    input  mul_start, mul_a, mul_b,
    output mul_result, mul_done, mul_busy
  );
endinterface

// File: rtl/affine_xform.sv
// Q(WIDTH-FRAC).FRAC 2-D affine transform sequencer:
//   x' = a*x + b*y + tx,  y' = c*x + d*y + ty
// Issues four products in sequence to one shared multiplier, accumulates them on top of the
// pre-shifted translation, then rounds half toward +inf and saturates back to WIDTH bits.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start                         request, only sampled while idle
//   coef_a..coef_d, tx, ty        signed matrix coefficients and translation
//   x_i, y_i                      signed input point
//   x_o, y_o                      registered transformed point, held until the next result
//   done                          one-cycle pulse, x_o/y_o valid
//   busy                          high from the cycle after acceptance through the done cycle
//   mul_if                        multiplier handshake (start, operands, product, done, busy)
module affine_xform #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] coef_a,
  input  logic [WIDTH-1:0] coef_b,
  input  logic [WIDTH-1:0] coef_c,
  input  logic [WIDTH-1:0] coef_d,
  input  logic [WIDTH-1:0] tx,
  input  logic [WIDTH-1:0] ty,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic             done,
  output logic             busy,
  affine_xform_if.master   mul_if
);

  // Two products plus a shifted translation per axis cannot overflow this width.
  localparam int unsigned AW = 2 * WIDTH + 2;

  localparam logic [WIDTH-1:0] MinVal     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MinPlusOne = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MaxVal     = {1'b0, {(WIDTH-1){1'b1}}};

  localparam logic signed [AW-1:0] Half   = AW'(1) << (FRAC - 1);
  localparam logic signed [AW-1:0] MaxExt = $signed({{(AW-WIDTH){1'b0}}, MaxVal});
  localparam logic signed [AW-1:0] MinExt = $signed({{(AW-WIDTH){1'b1}}, MinVal});

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StFinish} state_e;

  // The multiplier works on magnitudes, so the most negative value has no representation there.
  function automatic logic [WIDTH-1:0] clamp_min(input logic [WIDTH-1:0] v);
    return (v == MinVal) ? MinPlusOne : v;
  endfunction

  function automatic logic [WIDTH-1:0] round_sat(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] r;
    r = (acc + Half) >>> FRAC;
    if (r > MaxExt) begin
      return MaxVal;
    end else if (r < MinExt) begin
      return MinVal;
    end
    return r[WIDTH-1:0];
  endfunction

  state_e               state_q;
  logic [1:0]           idx_q;
  logic [WIDTH-1:0]     a_q, b_q, c_q, d_q, xv_q, yv_q;
  logic signed [AW-1:0] acc_x_q, acc_y_q;
  logic [WIDTH-1:0]     x_o_q, y_o_q;
  logic                 done_q, busy_q;

  logic [WIDTH-1:0]     x_d, y_d;
  logic [WIDTH-1:0]     tx_c, ty_c;
  logic signed [AW-1:0] tx_ext, ty_ext, prod_ext;

  always_comb begin
    tx_c     = clamp_min(tx);
    ty_c     = clamp_min(ty);
    tx_ext   = $signed({{(AW-WIDTH){tx_c[WIDTH-1]}}, tx_c});
    ty_ext   = $signed({{(AW-WIDTH){ty_c[WIDTH-1]}}, ty_c});
    prod_ext = $signed({{2{mul_if.mul_result[2*WIDTH-1]}}, mul_if.mul_result});
    x_d      = round_sat(acc_x_q);
    y_d      = round_sat(acc_y_q);
  end

  // Operands come straight from the latched values, so they stay stable until idx advances,
  // which is only after mul_done has been consumed.
  always_comb begin
    mul_if.mul_a = a_q;
    mul_if.mul_b = xv_q;
    case (idx_q)
      2'd0: begin mul_if.mul_a = a_q; mul_if.mul_b = xv_q; end
      2'd1: begin mul_if.mul_a = b_q; mul_if.mul_b = yv_q; end
      2'd2: begin mul_if.mul_a = c_q; mul_if.mul_b = xv_q; end
      default: begin mul_if.mul_a = d_q; mul_if.mul_b = yv_q; end
    endcase
  end

  assign mul_if.mul_start = (state_q == StIssue) && !mul_if.mul_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      xv_q    <= '0;
      yv_q    <= '0;
      acc_x_q <= '0;
      acc_y_q <= '0;
      x_o_q   <= '0;
      y_o_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Busy covers the done cycle; a start accepted in that cycle keeps it high.
      busy_q <= (state_q != StIdle) || start;
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= clamp_min(coef_a);
            b_q     <= clamp_min(coef_b);
            c_q     <= clamp_min(coef_c);
            d_q     <= clamp_min(coef_d);
            xv_q    <= clamp_min(x_i);
            yv_q    <= clamp_min(y_i);
            idx_q   <= '0;
            acc_x_q <= tx_ext <<< FRAC;
            acc_y_q <= ty_ext <<< FRAC;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (!mul_if.mul_busy) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (mul_if.mul_done) begin
            if (idx_q[1]) begin
              acc_y_q <= acc_y_q + prod_ext;
            end else begin
              acc_x_q <= acc_x_q + prod_ext;
            end
            if (idx_q == 2'd3) begin
              state_q <= StFinish;
            end else begin
              idx_q   <= idx_q + 2'd1;
              state_q <= StIssue;
            end
          end
        end
        StFinish: begin
          x_o_q   <= x_d;
          y_o_q   <= y_d;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign x_o  = x_o_q;
  assign y_o  = y_o_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_affine_xform.sv
module tb_affine_xform;
  localparam int W = 16;
  localparam int F = 8;

  typedef struct packed {
    logic [W-1:0] a, b, c, d, tx, ty, x, y;
  } vec_t;

  localparam vec_t VZero  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                              16'h0000, 16'h0000, 16'h0000, 16'h0000};
  localparam vec_t VIdent = '{16'h0100, 16'h0000, 16'h0000, 16'h0100,
                              16'h0000, 16'h0000, 16'h0280, 16'hFF00};
  localparam vec_t VRot   = '{16'h0000, 16'hFF00, 16'h0100, 16'h0000,
                              16'h0000, 16'h0000, 16'h0100, 16'h0200};
  localparam vec_t VScale = '{16'h0200, 16'h0000, 16'h0000, 16'h0080,
                              16'h0100, 16'hFF80, 16'h0300, 16'h0101};
  localparam vec_t VSat   = '{16'h7FFF, 16'h0000, 16'h0000, 16'h8000,
                              16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF};
  localparam vec_t VA     = '{16'h0180, 16'h0000, 16'h0000, 16'h0100,
                              16'h0000, 16'h0010, 16'h0100, 16'h0040};

  logic         clk, rst_n, start;
  logic [W-1:0] coef_a, coef_b, coef_c, coef_d, tx, ty, x_i, y_i;
  logic [W-1:0] x_o, y_o;
  logic         done, busy;

  int checks = 0;
  int failures = 0;
  int ms_count = 0;
  int done_count = 0;

  affine_xform_if #(.WIDTH(W)) mif ();

  affine_xform #(.WIDTH(W), .FRAC(F)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .coef_a (coef_a),
    .coef_b (coef_b),
    .coef_c (coef_c),
    .coef_d (coef_d),
    .tx     (tx),
    .ty     (ty),
    .x_i    (x_i),
    .y_i    (y_i),
    .x_o    (x_o),
    .y_o    (y_o),
    .done   (done),
    .busy   (busy),
    .mul_if (mif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 18-cycle multiplier: start seen in cycle t gives done in cycle t+18, product taken from
  // the live operands at the end, so operand instability shows up as a wrong result.
  int mul_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_cnt         <= 0;
      mif.mul_busy    <= 1'b0;
      mif.mul_done    <= 1'b0;
      mif.mul_result  <= '0;
    end else begin
      mif.mul_done <= 1'b0;
      if (mif.mul_start && !mif.mul_busy) begin
        mif.mul_busy <= 1'b1;
        mul_cnt      <= 17;
      end else if (mul_cnt == 1) begin
        mif.mul_done   <= 1'b1;
        mif.mul_busy   <= 1'b0;
        mul_cnt        <= 0;
        mif.mul_result <= $signed(mif.mul_a) * $signed(mif.mul_b);
      end else if (mul_cnt > 1) begin
        mul_cnt <= mul_cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] clamp16(input logic [W-1:0] v);
    return (v == 16'h8000) ? 16'h8001 : v;
  endfunction

  function automatic longint sv(input logic [W-1:0] v);
    logic signed [W-1:0] s;
    s = clamp16(v);
    return longint'(s);
  endfunction

  // p*q + r*s + t, all Q8.8; result rounded half-up and saturated to 16 bits.
  function automatic logic [W-1:0] axis(input longint p, input longint q, input longint r,
                                        input longint s, input longint t);
    longint acc;
    longint res;
    acc = p * q + r * s + t * (2 ** F);
    res = (acc + 2 ** (F - 1)) >>> F;
    if (res > 32767) return 16'h7FFF;
    if (res < -32768) return 16'h8000;
    return res[W-1:0];
  endfunction

  // Cycle-level expectation from the stated latency: start accepted in cycle s gives busy in
  // s+1..s+78, mul_start in s+1, s+20, s+39, s+58 and done/outputs in s+78.
  initial begin : compare
    bit           active;
    bit           accept;
    bit           exp_ms;
    int           rel;
    logic [W-1:0] hx, hy, px, py;
    logic [W-1:0] ea [4];
    logic [W-1:0] eb [4];
    active = 1'b0;
    rel    = 0;
    hx     = '0;
    hy     = '0;
    px     = '0;
    py     = '0;
    for (int i = 0; i < 4; i++) begin
      ea[i] = '0;
      eb[i] = '0;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
        rel    = 0;
        hx     = '0;
        hy     = '0;
      end
      exp_ms = active && (rel <= 58) && ((rel % 19) == 1);
      chk("busy", 32'(busy), 32'(active));
      chk("done", 32'(done), 32'(active && rel == 78));
      chk("mul_start", 32'(mif.mul_start), 32'(exp_ms));
      chk("x_o", 32'(x_o), 32'(hx));
      chk("y_o", 32'(y_o), 32'(hy));
      if (exp_ms) begin
        chk("mul_a", 32'(mif.mul_a), 32'(ea[(rel-1)/19]));
        chk("mul_b", 32'(mif.mul_b), 32'(eb[(rel-1)/19]));
      end
      if (mif.mul_start) ms_count++;
      if (done) done_count++;
      @(posedge clk);
      if (!rst_n) begin
        active = 1'b0;
        rel    = 0;
        hx     = '0;
        hy     = '0;
      end else begin
        accept = start && (!active || rel == 78);
        if (active && rel == 78) active = 1'b0;
        if (accept) begin
          px = axis(sv(coef_a), sv(x_i), sv(coef_b), sv(y_i), sv(tx));
          py = axis(sv(coef_c), sv(x_i), sv(coef_d), sv(y_i), sv(ty));
          ea[0] = clamp16(coef_a); eb[0] = clamp16(x_i);
          ea[1] = clamp16(coef_b); eb[1] = clamp16(y_i);
          ea[2] = clamp16(coef_c); eb[2] = clamp16(x_i);
          ea[3] = clamp16(coef_d); eb[3] = clamp16(y_i);
          active = 1'b1;
          rel    = 0;
        end
        if (active) begin
          rel++;
          if (rel == 78) begin
            hx = px;
            hy = py;
          end
        end
      end
    end
  end

  task automatic set_vec(input vec_t v);
    coef_a = v.a; coef_b = v.b; coef_c = v.c; coef_d = v.d;
    tx = v.tx; ty = v.ty; x_i = v.x; y_i = v.y;
  endtask

  // Pulses start for one cycle, then checks the done cycle against hand-computed literals.
  task automatic run_and_check(input string name, input vec_t v, input logic [W-1:0] ex,
                               input logic [W-1:0] ey);
    set_vec(v);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (77) @(posedge clk);
    #1;
    @(negedge clk);
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    chk({name, "_x"}, 32'(x_o), 32'(ex));
    chk({name, "_y"}, 32'(y_o), 32'(ey));
  endtask

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout, expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

  initial begin : stim
    rst_n = 1'b0;
    start = 1'b0;
    set_vec(VZero);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Each following op is started in the previous op's done cycle.
    run_and_check("ident", VIdent, 16'h0280, 16'hFF00);
    run_and_check("rot90", VRot,   16'hFE00, 16'h0100);
    run_and_check("scale", VScale, 16'h0700, 16'h0001);
    run_and_check("sat",   VSat,   16'h7FFF, 16'h8000);
    @(posedge clk);
    #1;

    // Second start while busy must be ignored.
    ms_count   = 0;
    done_count = 0;
    set_vec(VA);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    set_vec(VRot);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (47) @(posedge clk);
    #1;
    @(negedge clk);
    chk("ignore_done", 32'(done), 32'd1);
    chk("ignore_x", 32'(x_o), 32'h0180);
    chk("ignore_y", 32'(y_o), 32'h0050);
    repeat (40) @(posedge clk);
    #1;
    chk("mul_start_pulses", 32'(ms_count), 32'd4);
    chk("done_pulses", 32'(done_count), 32'd1);

    // Reset in the middle of an operation.
    set_vec(VScale);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (39) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mul_start", 32'(mif.mul_start), 32'd0);
    chk("rst_x", 32'(x_o), 32'd0);
    chk("rst_y", 32'(y_o), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    done_count = 0;
    repeat (100) @(posedge clk);
    #1;
    chk("no_done_after_reset", 32'(done_count), 32'd0);
    run_and_check("post_reset", VIdent, 16'h0280, 16'hFF00);

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
